bus_dev_port: RTL and testbench
===============================

Name: bus_dev_port

Overview:
- Device-side endpoint of the shared-bus protocol driven by bs_gnrtr_n_rbtr.
- One instance per bus driver.
- Presents a transmit FIFO to the bus: pndng, D_pop and pop.
- Accepts bus deliveries into an address-filtered receive FIFO: push and D_push.
- Exposes simple write/read ports to the local host, plus drop/overflow status.

Parameters:
- pckg_sz, 16: packet width; packet = {addr[7:0], payload[pckg_sz-9:0]}.
- depth, 8: entries per FIFO, power of two, at least 2.
- id, 0: this device's 8-bit address.
- broadcast, 8'hFF: broadcast address, always accepted.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  host writes wr_data into TX FIFO.
- wr_data  in  pckg_sz  packet to transmit.
- tx_full  out  1  TX FIFO full.
- pndng  out  1  TX FIFO non-empty (request to bus).
- D_pop  out  pckg_sz  TX FIFO head word.
- pop  in  1  bus consumes TX head.
- push  in  1  bus delivers D_push.
- D_push  in  pckg_sz  delivered packet.
- rd_en  in  1  host consumes RX head.
- rd_data  out  pckg_sz  RX FIFO head word.
- rx_valid  out  1  RX FIFO non-empty.
- tx_ovf  out  1  one-cycle pulse: host write dropped.
- rx_ovf  out  1  one-cycle pulse: accepted-address packet dropped because RX is full.
- addr_miss  out  1  one-cycle pulse: push with non-matching address.
- drop_cnt  out  8  saturating count of tx_ovf + rx_ovf + addr_miss events.

Behaviour:
- Reset (reset=0, asynchronous):
  - All pointers and occupancy counts go to 0.
  - pndng=0, tx_full=0, rx_valid=0, D_pop=0, rd_data=0.
  - All pulses are 0; drop_cnt=0.
  - Reset mid-operation discards both FIFO contents immediately.
  - Release is synchronous to clk: the first write can be taken on the first rising edge with reset=1.
- Both FIFOs:
  - Show-ahead: the head word is valid on the data output whenever the non-empty flag is 1.
  - Each FIFO keeps its own read/write pointers, wrapping modulo depth, plus an occupancy count 0..depth.
  - Flags derive from the registered count: full = (count==depth), non-empty = (count!=0).
  - Data outputs are 0 when empty.
- TX write:
  - If wr_en=1 and tx_full=0, the word is stored; pndng rises the next cycle when the FIFO was empty (1-cycle latency).
  - If wr_en=1 and tx_full=1, the word is discarded and tx_ovf pulses next cycle.
  - This holds even if pop=1 in the same cycle: a full FIFO never accepts a write.
- TX pop:
  - If pop=1 and pndng=1, the head advances and D_pop shows the next entry the following cycle.
  - pop with pndng=0 is ignored, with no error.
  - Simultaneous accepted write and pop leaves count unchanged.
- RX filter:
  - On push=1, a = D_push[pckg_sz-1 -: 8].
  - Accept when a==id or a==broadcast.
  - Otherwise discard and pulse addr_miss next cycle.
- RX store:
  - An accepted packet with RX count<depth is written; rx_valid rises next cycle when the FIFO was empty.
  - An accepted packet with RX full is discarded and rx_ovf pulses.
  - rd_en with rx_valid=1 advances the head.
  - rd_en with rx_valid=0 is ignored.
  - Simultaneous rd_en and accepted push when full: the push is still dropped (same rule as TX).
- drop_cnt:
  - Increments by the number of pulses asserted in a cycle, 0..3.
  - Saturates at 255 and never wraps.
- Pulse outputs are registered, high for exactly one cycle per event.

Test Plan:
- Basic TX path:
  - Stimulus: after reset, write 16'h0AB1 then 16'h02C2; pop on two consecutive cycles after pndng.
  - Response: pndng=1 one cycle after the first write; D_pop=0AB1, then 02C2; pndng=0 after the second pop.
- TX full/overflow (depth=8):
  - Stimulus: write 9 words with no pop.
  - Response: tx_full=1 after the 8th write; tx_ovf pulses once; drop_cnt=1; later pops return words 1..8 in order.
  - Stimulus: write while full with pop=1 in the same cycle.
  - Response: write dropped, count becomes 7.
- RX address filter (id=3):
  - Stimulus: push 16'h0311, 16'h0522, 16'hFF33.
  - Response: addr_miss pulses only for 0522; rd_data sequence 0311, FF33; drop_cnt=1.
- RX full and simultaneous read:
  - Stimulus: fill RX with 8 accepted packets; push a 9th accepted packet with rd_en=1 in the same cycle.
  - Response: 9th dropped, rx_ovf pulse, count 7.
- Wrap-around:
  - Stimulus: stream 20 words through TX with interleaved single pops, keeping occupancy at 1..3.
  - Response: order preserved, no ovf pulses.
- Async reset mid-stream and saturation:
  - Stimulus: assert reset between clock edges with both FIFOs non-empty.
  - Response: all outputs read as their reset values (0) immediately.
  - Stimulus: force 300 addr_miss events.
  - Response: drop_cnt holds 255.

Source files
------------

// File: rtl/bus_dev_port.sv
// Device-side endpoint of the shared bus: a show-ahead TX FIFO offered to the
// bus and an address-filtered show-ahead RX FIFO, with drop/overflow status.
module bus_dev_port #(
   parameter int unsigned pckg_sz   = 16,
   parameter int unsigned depth     = 8,
   parameter logic [7:0]  id        = 8'h00,
   parameter logic [7:0]  broadcast = 8'hFF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [pckg_sz-1:0] wr_data,
   output logic               tx_full,
   output logic               pndng,
   output logic [pckg_sz-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   input  logic               rd_en,
   output logic [pckg_sz-1:0] rd_data,
   output logic               rx_valid,
   output logic               tx_ovf,
   output logic               rx_ovf,
   output logic               addr_miss,
   output logic [7:0]         drop_cnt
);

   localparam int unsigned PW = $clog2(depth);
   localparam int unsigned CW = $clog2(depth + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(depth);

   logic [pckg_sz-1:0] tx_mem [depth];
   logic [pckg_sz-1:0] rx_mem [depth];
   logic [PW-1:0]      tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
   logic [CW-1:0]      tx_count, rx_count;

   logic       tx_wr_ok, tx_rd_ok, rx_wr_ok, rx_rd_ok;
   logic       addr_hit, rx_full;
   logic       tx_ovf_next, rx_ovf_next, miss_next;
   logic [1:0] drop_inc;
   logic [8:0] drop_sum;
   logic [7:0] push_addr;

   assign tx_full  = (tx_count == FULL_CNT);
   assign pndng    = (tx_count != '0);
   assign rx_full  = (rx_count == FULL_CNT);
   assign rx_valid = (rx_count != '0);

   assign D_pop   = pndng    ? tx_mem[tx_rd_ptr] : '0;
   assign rd_data = rx_valid ? rx_mem[rx_rd_ptr] : '0;

   // A full FIFO never accepts a write, even when its head is popped that cycle.
   assign tx_wr_ok = wr_en & ~tx_full;
   assign tx_rd_ok = pop & pndng;

   assign push_addr = D_push[pckg_sz-1 -: 8];
   assign addr_hit  = (push_addr == id) || (push_addr == broadcast);
   assign rx_wr_ok  = push & addr_hit & ~rx_full;
   assign rx_rd_ok  = rd_en & rx_valid;

   assign tx_ovf_next = wr_en & tx_full;
   assign rx_ovf_next = push & addr_hit & rx_full;
   assign miss_next   = push & ~addr_hit;

   assign drop_inc = {1'b0, tx_ovf_next} + {1'b0, rx_ovf_next} + {1'b0, miss_next};
   assign drop_sum = {1'b0, drop_cnt} + {7'b0, drop_inc};

   always_ff @(posedge clk) begin
      if (tx_wr_ok) tx_mem[tx_wr_ptr] <= wr_data;
      if (rx_wr_ok) rx_mem[rx_wr_ptr] <= D_push;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_wr_ok) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_rd_ok) tx_rd_ptr <= tx_rd_ptr + 1'b1;
         case ({tx_wr_ok, tx_rd_ok})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_wr_ok) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_rd_ok) rx_rd_ptr <= rx_rd_ptr + 1'b1;
         case ({rx_wr_ok, rx_rd_ok})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
      end
   end

   // Drop counter moves on the same edge that raises the matching pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_ovf    <= 1'b0;
         rx_ovf    <= 1'b0;
         addr_miss <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         tx_ovf    <= tx_ovf_next;
         rx_ovf    <= rx_ovf_next;
         addr_miss <= miss_next;
         drop_cnt  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

endmodule

// File: tb/tb_bus_dev_port.sv
// Scoreboard bench for bus_dev_port (id=3): queues hold the words the DUT
// must present, popped as the bus or host consumes them.
module tb_bus_dev_port;

   localparam logic [7:0] ID = 8'h03;

   logic        clk = 1'b0, reset = 1'b0;
   logic        wr_en = 1'b0, pop = 1'b0, push = 1'b0, rd_en = 1'b0;
   logic [15:0] wr_data = '0, D_push = '0;
   logic        tx_full, pndng, rx_valid, tx_ovf, rx_ovf, addr_miss;
   logic [15:0] D_pop, rd_data;
   logic [7:0]  drop_cnt;

   int          n_checks = 0;
   int          n_fail = 0;
   int          exp_drop = 0;
   logic [15:0] tx_q[$];
   logic [15:0] rx_q[$];
   logic [15:0] exp_w;

   bus_dev_port #(.pckg_sz(16), .depth(8), .id(ID), .broadcast(8'hFF)) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push),
      .rd_en(rd_en), .rd_data(rd_data), .rx_valid(rx_valid),
      .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .addr_miss(addr_miss),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_tx(input string name);
      while (tx_q.size() > 0) begin
         exp_w = tx_q.pop_front();
         n_checks++;
         if (pndng !== 1'b1 || D_pop !== exp_w) begin
            n_fail++;
            $display("[TB] FAIL %s drain: pndng=%b D_pop=%h, required pndng=1 D_pop=%h", name, pndng, D_pop, exp_w);
         end
         pop = 1'b1;
         tick();
         pop = 1'b0;
      end
      n_checks++;
      if (pndng !== 1'b0 || D_pop !== 16'h0) begin
         n_fail++;
         $display("[TB] FAIL %s empty: pndng=%b D_pop=%h, required 0/0000", name, pndng, D_pop);
      end
   endtask

   task automatic drain_rx(input string name);
      while (rx_q.size() > 0) begin
         exp_w = rx_q.pop_front();
         n_checks++;
         if (rx_valid !== 1'b1 || rd_data !== exp_w) begin
            n_fail++;
            $display("[TB] FAIL %s drain: rx_valid=%b rd_data=%h, required 1/%h", name, rx_valid, rd_data, exp_w);
         end
         rd_en = 1'b1;
         tick();
         rd_en = 1'b0;
      end
      n_checks++;
      if (rx_valid !== 1'b0 || rd_data !== 16'h0) begin
         n_fail++;
         $display("[TB] FAIL %s empty: rx_valid=%b rd_data=%h, required 0/0000", name, rx_valid, rd_data);
      end
   endtask

   task automatic test_reset();
      tick();
      n_checks++;
      if ({pndng, tx_full, rx_valid, tx_ovf, rx_ovf, addr_miss} !== 6'b0 ||
          D_pop !== 16'h0 || rd_data !== 16'h0 || drop_cnt !== 8'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_state: flags=%b D_pop=%h rd_data=%h drop=%0d, required all 0",
                  {pndng, tx_full, rx_valid, tx_ovf, rx_ovf, addr_miss}, D_pop, rd_data, drop_cnt);
      end
      reset = 1'b1;
   endtask

   task automatic test_basic_tx();
      wr_en = 1'b1; wr_data = 16'h0AB1; tx_q.push_back(wr_data);
      tick();
      n_checks++;
      if (pndng !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL basic_pndng: got %b, required 1", pndng);
      end
      wr_data = 16'h02C2; tx_q.push_back(wr_data);
      tick();
      wr_en = 1'b0;
      drain_tx("basic_tx");
   endtask

   task automatic test_tx_overflow();
      wr_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wr_data = 16'h0100 + 16'(i + 1);
         if (i < 8) tx_q.push_back(wr_data);
         tick();
         if (i == 7) begin
            n_checks++;
            if (tx_full !== 1'b1 || tx_ovf !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL tx_full_8th: tx_full=%b tx_ovf=%b, required 1/0", tx_full, tx_ovf);
            end
         end
      end
      exp_drop++;
      n_checks++;
      if (tx_ovf !== 1'b1 || drop_cnt !== 8'(exp_drop)) begin
         n_fail++;
         $display("[TB] FAIL tx_ovf_9th: tx_ovf=%b drop=%0d, required 1/%0d", tx_ovf, drop_cnt, exp_drop);
      end
      wr_en = 1'b0;
      tick();
      n_checks++;
      if (tx_ovf !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL tx_ovf_width: got %b, required 0", tx_ovf);
      end
      exp_w = tx_q.pop_front();
      n_checks++;
      if (D_pop !== exp_w) begin
         n_fail++;
         $display("[TB] FAIL full_pop_head: got %h, required %h", D_pop, exp_w);
      end
      wr_en = 1'b1; pop = 1'b1; wr_data = 16'hDEAD;
      tick();
      wr_en = 1'b0; pop = 1'b0;
      exp_drop++;
      n_checks++;
      if (tx_ovf !== 1'b1 || tx_full !== 1'b0 || drop_cnt !== 8'(exp_drop)) begin
         n_fail++;
         $display("[TB] FAIL full_wr_pop: tx_ovf=%b tx_full=%b drop=%0d, required 1/0/%0d",
                  tx_ovf, tx_full, drop_cnt, exp_drop);
      end
      drain_tx("tx_overflow");
   endtask

   task automatic test_rx_filter();
      logic [15:0] pkts [3];
      pkts[0] = 16'h0311; pkts[1] = 16'h0522; pkts[2] = 16'hFF33;
      for (int i = 0; i < 3; i++) begin
         push = 1'b1; D_push = pkts[i];
         if (i != 1) rx_q.push_back(pkts[i]);
         tick();
         n_checks++;
         if (addr_miss !== (i == 1)) begin
            n_fail++;
            $display("[TB] FAIL addr_miss_%0d: got %b, required %b", i, addr_miss, (i == 1));
         end
      end
      push = 1'b0;
      exp_drop++;
      tick();
      n_checks++;
      if (drop_cnt !== 8'(exp_drop) || addr_miss !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rx_filter_drop: drop=%0d miss=%b, required %0d/0", drop_cnt, addr_miss, exp_drop);
      end
      drain_rx("rx_filter");
   endtask

   task automatic test_rx_full();
      push = 1'b1;
      for (int i = 0; i < 8; i++) begin
         D_push = {(i % 2 == 0) ? ID : 8'hFF, 8'(8'h40 + i)};
         rx_q.push_back(D_push);
         tick();
      end
      exp_w = rx_q.pop_front();
      n_checks++;
      if (rd_data !== exp_w) begin
         n_fail++;
         $display("[TB] FAIL rx_full_head: got %h, required %h", rd_data, exp_w);
      end
      D_push = {ID, 8'h99}; rd_en = 1'b1;
      tick();
      push = 1'b0; rd_en = 1'b0;
      exp_drop++;
      n_checks++;
      if (rx_ovf !== 1'b1 || drop_cnt !== 8'(exp_drop) || addr_miss !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rx_ovf: rx_ovf=%b drop=%0d miss=%b, required 1/%0d/0", rx_ovf, drop_cnt, addr_miss, exp_drop);
      end
      tick();
      n_checks++;
      if (rx_ovf !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rx_ovf_width: got %b, required 0", rx_ovf);
      end
      drain_rx("rx_full");
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; wr_data = 16'h1000 + 16'(i);
         pop = (tx_q.size() >= 3) || (tx_q.size() == 2 && (i % 2 == 1));
         if (pop) begin
            exp_w = tx_q.pop_front();
            n_checks++;
            if (D_pop !== exp_w) begin
               n_fail++;
               $display("[TB] FAIL wrap_order_%0d: got %h, required %h", i, D_pop, exp_w);
            end
         end
         tx_q.push_back(wr_data);
         tick();
         n_checks++;
         if (tx_ovf !== 1'b0 || tx_full !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wrap_flags_%0d: tx_ovf=%b tx_full=%b, required 0/0", i, tx_ovf, tx_full);
         end
      end
      wr_en = 1'b0; pop = 1'b0;
      drain_tx("wrap");
   endtask

   task automatic test_async_reset();
      wr_en = 1'b1; wr_data = 16'h0A0A; push = 1'b1; D_push = {ID, 8'h77};
      tick();
      tick();
      wr_en = 1'b0; push = 1'b0;
      n_checks++;
      if (pndng !== 1'b1 || rx_valid !== 1'b1 || drop_cnt === 8'h0) begin
         n_fail++;
         $display("[TB] FAIL pre_reset: pndng=%b rx_valid=%b drop=%0d, required 1/1/nonzero", pndng, rx_valid, drop_cnt);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({pndng, tx_full, rx_valid, tx_ovf, rx_ovf, addr_miss} !== 6'b0 ||
          D_pop !== 16'h0 || rd_data !== 16'h0 || drop_cnt !== 8'h0) begin
         n_fail++;
         $display("[TB] FAIL async_reset: flags=%b D_pop=%h rd_data=%h drop=%0d, required all 0",
                  {pndng, tx_full, rx_valid, tx_ovf, rx_ovf, addr_miss}, D_pop, rd_data, drop_cnt);
      end
      tx_q.delete(); rx_q.delete(); exp_drop = 0;
      @(posedge clk); #1;
      reset = 1'b1;
      pop = 1'b1; rd_en = 1'b1;
      tick();
      pop = 1'b0; rd_en = 1'b0;
      n_checks++;
      if (pndng !== 1'b0 || rx_valid !== 1'b0 || drop_cnt !== 8'h0) begin
         n_fail++;
         $display("[TB] FAIL empty_pop_ignored: pndng=%b rx_valid=%b drop=%0d, required 0/0/0", pndng, rx_valid, drop_cnt);
      end
   endtask

   task automatic test_multi_drop();
      wr_en = 1'b1; push = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wr_data = 16'h2000 + 16'(i); D_push = {ID, 8'(i)};
         tick();
      end
      D_push = {8'hFF, 8'hEE};
      tick();
      exp_drop += 2;
      n_checks++;
      if (tx_ovf !== 1'b1 || rx_ovf !== 1'b1 || drop_cnt !== 8'(exp_drop)) begin
         n_fail++;
         $display("[TB] FAIL double_drop: tx_ovf=%b rx_ovf=%b drop=%0d, required 1/1/%0d", tx_ovf, rx_ovf, drop_cnt, exp_drop);
      end
      D_push = {8'h44, 8'h00};
      tick();
      exp_drop += 2;
      wr_en = 1'b0; push = 1'b0;
      n_checks++;
      if (tx_ovf !== 1'b1 || addr_miss !== 1'b1 || rx_ovf !== 1'b0 || drop_cnt !== 8'(exp_drop)) begin
         n_fail++;
         $display("[TB] FAIL ovf_and_miss: tx_ovf=%b miss=%b rx_ovf=%b drop=%0d, required 1/1/0/%0d",
                  tx_ovf, addr_miss, rx_ovf, drop_cnt, exp_drop);
      end
   endtask

   task automatic test_saturation();
      push = 1'b1;
      for (int i = 0; i < 300; i++) begin
         D_push = {8'h55, 8'(i)};
         tick();
         exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
         n_checks++;
         if (addr_miss !== 1'b1 || drop_cnt !== 8'(exp_drop)) begin
            n_fail++;
            $display("[TB] FAIL saturate_%0d: miss=%b drop=%0d, required 1/%0d", i, addr_miss, drop_cnt, exp_drop);
         end
      end
      push = 1'b0;
      tick();
      n_checks++;
      if (addr_miss !== 1'b0 || drop_cnt !== 8'd255) begin
         n_fail++;
         $display("[TB] FAIL saturate_hold: miss=%b drop=%0d, required 0/255", addr_miss, drop_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic_tx();
      test_tx_overflow();
      test_rx_filter();
      test_rx_full();
      test_wrap();
      test_async_reset();
      test_multi_drop();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
